acq_udp_packetizer: RTL
=======================

Name: acq_udp_packetizer

Overview:
Sits between the acquisition FIFOs (108-bit words, show-ahead) and the UDP TX FIFO pair of the 1 Gb Ethernet wrapper on port 2. It packs a configurable number of acquisition words into one UDP payload as big-endian bytes. After the last byte it writes the 96-bit status word that triggers transmission to the client. All logic runs in the rx_xcvr_clk (125 MHz) domain.

Parameters:
WORDS_PER_PACKET, 100, acquisition words per full packet (1..4681); 100 gives a 1400-byte payload.
FLUSH_TIMEOUT, 12500, idle cycles before a partial packet is closed (100 us at 125 MHz); 0 disables flushing.
TIMEOUT_W, 16, width of the flush timeout counter.

Ports:
clk  input  1  clock (rx_xcvr_clk)
reset_n  input  1  asynchronous active-low reset
enable  input  1  level; packets start only while high
destination_mac  input  48  client MAC, sampled at packet start
destination_ip  input  32  client IP, sampled at packet start
acq_rdreq  output  1  pop strobe to the show-ahead acquisition FIFO
acq_rddata  input  108  acquisition word, valid while acq_rdempty=0
acq_rdempty  input  1  acquisition FIFO empty
tx_fifo_data  output  8  payload byte
tx_fifo_data_write  output  1  byte write strobe
tx_fifo_data_full  input  1  TX data FIFO full
tx_fifo_status  output  96  {dest_mac[47:0], dest_ip[31:0], payload_len[15:0]}
tx_fifo_status_write  output  1  status write strobe
tx_fifo_status_full  input  1  TX status FIFO full
busy  output  1  high in every state except IDLE
packet_count  output  32  packets whose status has been written; wraps at 2^32

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all outputs 0; shift register, byte, word and timeout counters 0; packet_count 0.
- IDLE: go to LOAD when enable=1, acq_rdempty=0 and tx_fifo_status_full=0. On that transition, latch destination_mac and destination_ip and clear word_cnt.
- LOAD (1 cycle): assert acq_rdreq for exactly this cycle. Capture {4'b0000, acq_rddata} into a 112-bit shift register, set byte_idx=0, increment word_cnt, go to SEND.
- SEND: each cycle with tx_fifo_data_full=0, drive tx_fifo_data = shift[111:104], pulse tx_fifo_data_write, shift left 8, increment byte_idx. When full=1, hold with no write and no shift.
  - Byte order: byte0 = {4'b0, word[107:104]}, ..., byte13 = word[7:0].
  - Steady-state throughput: 14 bytes per word plus 1 LOAD cycle = 15 cycles per word.
- After the 14th byte is written:
  - word_cnt == WORDS_PER_PACKET -> STATUS.
  - else acq_rdempty=0 -> LOAD.
  - else -> WAIT.
- WAIT: timeout counter increments each cycle and clears on exit.
  - acq_rdempty=0 -> LOAD. Data availability wins if it coincides with a timeout hit.
  - Counter reaches FLUSH_TIMEOUT-1 (FLUSH_TIMEOUT>0) -> STATUS.
  - enable deasserted is ignored here; the packet still completes or flushes.
- STATUS: when tx_fifo_status_full=0, drive tx_fifo_status with the latched MAC/IP and payload_len = word_cnt*14 (plus 4 with the option). Pulse tx_fifo_status_write for 1 cycle, increment packet_count, go to IDLE. Otherwise hold.
- Exactly one status write per packet. A status is never written before all of its payload bytes.
- Deasserting enable never truncates a packet. It only blocks the IDLE->LOAD start.
- Reset mid-packet: the partial payload already in the TX data FIFO is abandoned. The system reset also clears the Ethernet FIFOs, so no recovery is required of this block.
- acq_rdreq is never asserted while acq_rdempty=1.

Optional Feature:
Macro PACKETIZER_SEQ_HEADER_EN.
- Defined: add state HDR between IDLE and the first LOAD. HDR emits 4 bytes of packet_count, MSB first, obeying the same full stall rule, and payload_len includes +4.
- Undefined: HDR state is absent, the payload is pure data, and payload_len = word_cnt*14.

Test Plan:
- WORDS_PER_PACKET=2, FIFO preloaded with 0x123456789ABCDEF0123456789AB and 0xFFF...F (108 ones), enable=1 -> 28 bytes 0x01,0x23,...,0xAB,0x0F,0xFF,...; status {mac, ip, 16'd28}; packet_count=1; exactly 2 acq_rdreq pulses.
- Toggle tx_fifo_data_full high for 5 cycles at byte 7 -> no write and no shift while full; byte sequence unchanged; total cycles +5.
- WORDS_PER_PACKET=100, FLUSH_TIMEOUT=50, 3 words then FIFO empty -> status written 50 cycles after last byte with payload_len=42; a word arriving at cycle 49 instead goes to LOAD and no status is written.
- tx_fifo_status_full=1 in IDLE with data present -> no acq_rdreq; release -> packet starts; status_full raised at STATUS -> hold until it falls, then one write.
- Drop enable mid-packet -> packet completes with full length, then FSM stays in IDLE; assert reset_n=0 mid-SEND -> all outputs 0 asynchronously, packet_count=0.
- With PACKETIZER_SEQ_HEADER_EN, 3 packets -> headers 00000000, 00000001, 00000002; payload_len=14*N+4.

Source files
------------

// File: rtl/acq_udp_packetizer.sv
// Packs 108-bit acquisition words into big-endian UDP payload bytes, then writes the TX status word.
// Optional macro PACKETIZER_SEQ_HEADER_EN prepends a 4-byte packet sequence number to each payload.
module acq_udp_packetizer #(
    parameter int unsigned WORDS_PER_PACKET = 100,
    parameter int unsigned FLUSH_TIMEOUT    = 12500,
    parameter int unsigned TIMEOUT_W        = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [47:0]  destination_mac,
    input  logic [31:0]  destination_ip,
    output logic         acq_rdreq,
    input  logic [107:0] acq_rddata,
    input  logic         acq_rdempty,
    output logic [7:0]   tx_fifo_data,
    output logic         tx_fifo_data_write,
    input  logic         tx_fifo_data_full,
    output logic [95:0]  tx_fifo_status,
    output logic         tx_fifo_status_write,
    input  logic         tx_fifo_status_full,
    output logic         busy,
    output logic [31:0]  packet_count
);
    localparam int unsigned SHIFT_W        = 112;
    localparam int unsigned BYTES_PER_WORD = 14;
    localparam int unsigned WCNT_W         = 13;
    localparam int unsigned LEN_W          = 16;
`ifdef PACKETIZER_SEQ_HEADER_EN
    localparam int unsigned HDR_BYTES      = 4;
`else
    localparam int unsigned HDR_BYTES      = 0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SEND   = 3'd2,
        S_WAIT   = 3'd3,
        S_STATUS = 3'd4
`ifdef PACKETIZER_SEQ_HEADER_EN
        ,S_HDR   = 3'd5
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [3:0]           byte_idx_q, byte_idx_d;
    logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
    logic [47:0]          mac_q, mac_d;
    logic [31:0]          ip_q, ip_d;
    logic                 rdreq_d;
    logic [7:0]           data_d;
    logic                 data_write_d;
    logic [95:0]          status_d;
    logic                 status_write_d;
    logic                 busy_d;
    logic [31:0]          packet_count_d;
    logic [LEN_W-1:0]     payload_len_c;

    assign payload_len_c = LEN_W'(32'(word_cnt_q) * BYTES_PER_WORD + HDR_BYTES);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q              <= S_IDLE;
            shift_q              <= '0;
            byte_idx_q           <= '0;
            word_cnt_q           <= '0;
            tcnt_q               <= '0;
            mac_q                <= '0;
            ip_q                 <= '0;
            acq_rdreq            <= 1'b0;
            tx_fifo_data         <= '0;
            tx_fifo_data_write   <= 1'b0;
            tx_fifo_status       <= '0;
            tx_fifo_status_write <= 1'b0;
            busy                 <= 1'b0;
            packet_count         <= '0;
        end else begin
            state_q              <= state_d;
            shift_q              <= shift_d;
            byte_idx_q           <= byte_idx_d;
            word_cnt_q           <= word_cnt_d;
            tcnt_q               <= tcnt_d;
            mac_q                <= mac_d;
            ip_q                 <= ip_d;
            acq_rdreq            <= rdreq_d;
            tx_fifo_data         <= data_d;
            tx_fifo_data_write   <= data_write_d;
            tx_fifo_status       <= status_d;
            tx_fifo_status_write <= status_write_d;
            busy                 <= busy_d;
            packet_count         <= packet_count_d;
        end
    end

    // Next-state and next-output logic; rdreq is raised on entry so it is high during LOAD
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        byte_idx_d     = byte_idx_q;
        word_cnt_d     = word_cnt_q;
        tcnt_d         = tcnt_q;
        mac_d          = mac_q;
        ip_d           = ip_q;
        rdreq_d        = 1'b0;
        data_d         = tx_fifo_data;
        data_write_d   = 1'b0;
        status_d       = tx_fifo_status;
        status_write_d = 1'b0;
        packet_count_d = packet_count;

        case (state_q)
            S_IDLE: begin
                if (enable && !acq_rdempty && !tx_fifo_status_full) begin
                    mac_d      = destination_mac;
                    ip_d       = destination_ip;
                    word_cnt_d = '0;
`ifdef PACKETIZER_SEQ_HEADER_EN
                    shift_d    = {packet_count, 80'h0};
                    byte_idx_d = '0;
                    state_d    = S_HDR;
`else
                    rdreq_d    = 1'b1;
                    state_d    = S_LOAD;
`endif
                end
            end
`ifdef PACKETIZER_SEQ_HEADER_EN
            S_HDR: begin
                if (!tx_fifo_data_full) begin
                    data_d       = shift_q[111:104];
                    data_write_d = 1'b1;
                    shift_d      = shift_q << 8;
                    byte_idx_d   = byte_idx_q + 4'd1;
                    if (byte_idx_q == 4'd3) begin
                        rdreq_d = 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
`endif
            S_LOAD: begin
                shift_d    = SHIFT_W'(acq_rddata);
                byte_idx_d = '0;
                word_cnt_d = word_cnt_q + WCNT_W'(1);
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (!tx_fifo_data_full) begin
                    data_d       = shift_q[111:104];
                    data_write_d = 1'b1;
                    shift_d      = shift_q << 8;
                    byte_idx_d   = byte_idx_q + 4'd1;
                    if (byte_idx_q == 4'(BYTES_PER_WORD - 1)) begin
                        if (word_cnt_q == WCNT_W'(WORDS_PER_PACKET)) begin
                            state_d = S_STATUS;
                        end else if (!acq_rdempty) begin
                            rdreq_d = 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            tcnt_d  = '0;
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                // Fresh data takes priority over a coincident flush timeout
                if (!acq_rdempty) begin
                    tcnt_d  = '0;
                    rdreq_d = 1'b1;
                    state_d = S_LOAD;
                end else if ((FLUSH_TIMEOUT != 0) &&
                             (tcnt_q == TIMEOUT_W'(FLUSH_TIMEOUT - 1))) begin
                    tcnt_d  = '0;
                    state_d = S_STATUS;
                end else begin
                    tcnt_d  = tcnt_q + TIMEOUT_W'(1);
                end
            end
            S_STATUS: begin
                if (!tx_fifo_status_full) begin
                    status_d       = {mac_q, ip_q, payload_len_c};
                    status_write_d = 1'b1;
                    packet_count_d = packet_count + 32'd1;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end
endmodule
